// File: rtl/match_template_mac_pipe_if.sv
// match_template_mac_pipe_if: operand/result bundle between a MAC pipe and its driver
interface match_template_mac_pipe_if #(
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26
);
  logic                  ce;
  logic                  vld_in;
  logic                  acc_en;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic [dout_WIDTH-1:0] dout;
  logic                  vld_out;
  logic                  ovf_out;
  modport master (output ce, vld_in, acc_en, din0, din1, input dout, vld_out, ovf_out);
  modport slave  (input ce, vld_in, acc_en, din0, din1, output dout, vld_out, ovf_out);
endinterface

// File: rtl/match_template_mac_pipe.sv
// match_template_mac_pipe: pipelined multiply-accumulate with clock enable, load/accumulate select and overflow flag
module match_template_mac_pipe #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 5,
  parameter int din0_WIDTH  = 14,
  parameter int din1_WIDTH  = 12,
  parameter int dout_WIDTH  = 26,
  parameter int SIGNED_MODE = 0
) (
  input logic clk,
  input logic reset,
  match_template_mac_pipe_if.slave s
);
  localparam int D = NUM_STAGE - 2;
  localparam int M = dout_WIDTH - 1;
  localparam int unused_id = ID;
  logic                  s1_vld, s1_acc;
  logic [din0_WIDTH-1:0] s1_d0;
  logic [din1_WIDTH-1:0] s1_d1;
  logic [D-1:0]          p_vld, p_acc;
  logic [dout_WIDTH-1:0] p_prod [D];
  logic [dout_WIDTH-1:0] prod, last, dout_q;
  logic [dout_WIDTH:0]   sum;
  logic                  vld_q, ovf_q, ovf_add;
  // Only the low dout_WIDTH bits survive, so the multiply runs at that width
  always_comb begin
    prod = (SIGNED_MODE != 0 ? dout_WIDTH'($signed(s1_d0)) : dout_WIDTH'(s1_d0)) *
           (SIGNED_MODE != 0 ? dout_WIDTH'($signed(s1_d1)) : dout_WIDTH'(s1_d1));
    last = p_prod[D-1];
    sum = {1'b0, dout_q} + {1'b0, last};
    ovf_add = SIGNED_MODE != 0 ? (dout_q[M] == last[M]) && (sum[M] != dout_q[M]) : sum[dout_WIDTH];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
      p_vld  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (s.ce) begin
      s1_vld    <= s.vld_in;
      s1_acc    <= s.acc_en;
      s1_d0     <= s.din0;
      s1_d1     <= s.din1;
      p_vld[0]  <= s1_vld;
      p_acc[0]  <= s1_acc;
      p_prod[0] <= prod;
      for (int i = 1; i < D; i++) begin
        p_vld[i]  <= p_vld[i-1];
        p_acc[i]  <= p_acc[i-1];
        p_prod[i] <= p_prod[i-1];
      end
      vld_q <= p_vld[D-1];
      if (p_vld[D-1]) begin
        dout_q <= p_acc[D-1] ? sum[M:0] : last;
        ovf_q  <= p_acc[D-1] & ovf_add;
      end
    end
  end
  assign s.dout    = dout_q;
  assign s.vld_out = vld_q;
  assign s.ovf_out = ovf_q;
endmodule

// File: tb/tb_match_template_mac_pipe.sv
// tb_match_template_mac_pipe: directed and random checks of three MAC pipe configurations against a queue-based model
module tb_match_template_mac_pipe;
  localparam int NS = 5;
  logic clk = 1'b0;
  logic reset, ce, vld_in, acc_en;
  logic [13:0] din0;
  logic [11:0] din1;
  always #5 clk = ~clk;
  match_template_mac_pipe_if #(.dout_WIDTH(26)) b0 ();
  match_template_mac_pipe_if #(.dout_WIDTH(8))  b1 ();
  match_template_mac_pipe_if #(.dout_WIDTH(26)) b2 ();
  assign {b0.ce, b0.vld_in, b0.acc_en, b0.din0, b0.din1} = {ce, vld_in, acc_en, din0, din1};
  assign {b1.ce, b1.vld_in, b1.acc_en, b1.din0, b1.din1} = {ce, vld_in, acc_en, din0, din1};
  assign {b2.ce, b2.vld_in, b2.acc_en, b2.din0, b2.din1} = {ce, vld_in, acc_en, din0, din1};
  match_template_mac_pipe #(.NUM_STAGE(NS))                 u0 (.clk(clk), .reset(reset), .s(b0));
  match_template_mac_pipe #(.NUM_STAGE(NS), .dout_WIDTH(8)) u1 (.clk(clk), .reset(reset), .s(b1));
  match_template_mac_pipe #(.NUM_STAGE(NS), .SIGNED_MODE(1)) u2 (.clk(clk), .reset(reset), .s(b2));
  typedef struct {int due; longint d0; longint d1; bit acc;} op_t;
  op_t    q[$];
  int     cw[3] = '{26, 8, 26};
  bit     cs[3] = '{1'b0, 1'b0, 1'b1};
  longint acc_m[3];
  bit     ovf_m[3];
  bit     vld_m;
  int     n_en, n_cmp, n_err;
  task automatic chk(string tag, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic longint sx(longint v, int w);
    return ((v >> (w - 1)) & 1) != 0 ? v - (longint'(1) << w) : v;
  endfunction
  function automatic void apply(int i, op_t o);
    longint m, a, b, pm, t;
    m  = (longint'(1) << cw[i]) - 1;
    a  = cs[i] ? sx(o.d0, 14) : o.d0;
    b  = cs[i] ? sx(o.d1, 12) : o.d1;
    pm = (a * b) & m;
    if (!o.acc) begin
      acc_m[i] = pm;
      ovf_m[i] = 1'b0;
    end else if (!cs[i]) begin
      t = acc_m[i] + pm;
      ovf_m[i] = t > m;
      acc_m[i] = t & m;
    end else begin
      t = sx(acc_m[i], cw[i]) + sx(pm, cw[i]);
      ovf_m[i] = t > (m >> 1) || t < -((m >> 1) + 1);
      acc_m[i] = t & m;
    end
  endfunction
  task automatic step();
    longint ad[3];
    bit av[3], ao[3];
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      vld_m = 1'b0;
      for (int i = 0; i < 3; i++) begin
        acc_m[i] = 0;
        ovf_m[i] = 1'b0;
      end
    end else if (ce) begin
      n_en++;
      vld_m = 1'b0;
      if (q.size() > 0 && q[0].due == n_en) begin
        op_t o = q.pop_front();
        vld_m = 1'b1;
        for (int i = 0; i < 3; i++) apply(i, o);
      end
      if (vld_in) q.push_back('{n_en + NS - 1, longint'(din0), longint'(din1), acc_en});
    end
    ad = '{longint'(b0.dout), longint'(b1.dout), longint'(b2.dout)};
    av = '{b0.vld_out, b1.vld_out, b2.vld_out};
    ao = '{b0.ovf_out, b1.ovf_out, b2.ovf_out};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("vld_out[%0d]", i), longint'(av[i]), longint'(vld_m));
      chk($sformatf("dout[%0d]", i), ad[i], acc_m[i]);
      chk($sformatf("ovf_out[%0d]", i), longint'(ao[i]), longint'(ovf_m[i]));
    end
  endtask
  task automatic op(longint a, longint b, bit ac);
    vld_in = 1'b1;
    din0 = 14'(a);
    din1 = 12'(b);
    acc_en = ac;
    step();
    vld_in = 1'b0;
  endtask
  task automatic idle(int n);
    vld_in = 1'b0;
    repeat (n) step();
  endtask
  initial begin
    logic [31:0] r;
    reset = 1'b1; ce = 1'b1; vld_in = 1'b0; acc_en = 1'b0; din0 = '0; din1 = '0;
    step(); step();
    chk("rst_dout", longint'(b0.dout), 0);
    chk("rst_vld", longint'(b0.vld_out), 0);
    reset = 1'b0;
    op(100, 3, 0);
    idle(4);
    chk("single_vld", longint'(b0.vld_out), 1);
    chk("single_dout", longint'(b0.dout), 300);
    idle(1);
    chk("single_vld_drop", longint'(b0.vld_out), 0);
    op(2, 5, 0); op(3, 4, 1); op(1, 1, 1); op(10, 10, 0);
    for (int i = 0; i < 4; i++) begin
      longint seq[4] = '{10, 22, 23, 100};
      idle(1);
      chk("chain_vld", longint'(b0.vld_out), 1);
      chk("chain_dout", longint'(b0.dout), seq[i]);
    end
    idle(2);
    op(7, 9, 0);
    idle(1);
    ce = 1'b0;
    idle(3);
    ce = 1'b1;
    idle(2);
    chk("stall_early_vld", longint'(b0.vld_out), 0);
    idle(1);
    chk("stall_vld", longint'(b0.vld_out), 1);
    chk("stall_dout", longint'(b0.dout), 63);
    idle(2);
    op(16, 15, 0); op(2, 10, 1); op(1, 1, 0);
    idle(2);
    chk("w8_load", longint'(b1.dout), 240);
    idle(1);
    chk("w8_wrap_dout", longint'(b1.dout), 4);
    chk("w8_wrap_ovf", longint'(b1.ovf_out), 1);
    idle(1);
    chk("w8_reload_dout", longint'(b1.dout), 1);
    chk("w8_reload_ovf", longint'(b1.ovf_out), 0);
    idle(2);
    op(-3, 7, 0); op(3, 7, 1);
    idle(3);
    chk("sgn_load", longint'(b2.dout), (longint'(1) << 26) - 21);
    idle(1);
    chk("sgn_zero_dout", longint'(b2.dout), 0);
    chk("sgn_zero_ovf", longint'(b2.ovf_out), 0);
    op(5, 5, 0); op(6, 6, 1); op(7, 7, 1);
    reset = 1'b1; vld_in = 1'b1; ce = 1'b0;
    step();
    reset = 1'b0; vld_in = 1'b0; ce = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("flush_vld", longint'(b0.vld_out), 0);
      chk("flush_dout", longint'(b0.dout), 0);
    end
    op(4, 5, 0);
    idle(4);
    chk("post_rst_dout", longint'(b0.dout), 20);
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      reset  = $urandom_range(0, 99) == 0;
      ce     = $urandom_range(0, 4) != 0;
      vld_in = $urandom_range(0, 9) < 7;
      acc_en = $urandom_range(0, 3) != 0;
      din0   = r[1:0] == 2'd0 ? 14'h3fff : r[1:0] == 2'd1 ? 14'h2000 : 14'($urandom);
      din1   = r[3:2] == 2'd0 ? 12'hfff : r[3:2] == 2'd1 ? 12'h800 : 12'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/match_template_mac_pipe.md
MATCH_TEMPLATE_MAC_PIPE -- requirements
Module: match_template_mac_pipe

Interface
REQ-001 Parameter ID, default 1, instance tag; SHALL have no functional effect.
REQ-002 Parameter NUM_STAGE, default 5, total latency in ce-enabled cycles; legal range 3..16.
REQ-003 Parameter din0_WIDTH, default 14, width of operand 0.
REQ-004 Parameter din1_WIDTH, default 12, width of operand 1.
REQ-005 Parameter dout_WIDTH, default 26, width of the product path and the accumulator.
REQ-006 Parameter SIGNED_MODE, default 0; 0 zero-extends both operands, 1 sign-extends both operands.
REQ-007 clk  input  1  rising-edge clock; the only clock.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 ce  input  1  clock enable; when low, every register SHALL hold.
REQ-010 vld_in  input  1  din0/din1/acc_en qualify a new operation on this ce-enabled edge.
REQ-011 din0  input  din0_WIDTH  operand 0.
REQ-012 din1  input  din1_WIDTH  operand 1.
REQ-013 acc_en  input  1  1 = add product to accumulator; 0 = load product into accumulator.
REQ-014 dout  output  dout_WIDTH  accumulator value.
REQ-015 vld_out  output  1  dout was updated on the previous ce-enabled edge.
REQ-016 ovf_out  output  1  the accumulate that produced the current dout wrapped.

Function
REQ-017 Stage 1 SHALL register din0, din1, acc_en and vld_in on each edge where ce=1.
REQ-018 The product SHALL be formed from the stage-1 registers, extended per SIGNED_MODE, computed at full width, and truncated to its low dout_WIDTH bits.
REQ-019 Stages 2..NUM_STAGE-1 SHALL be plain delay registers carrying the product, acc_en and the valid bit.
REQ-020 Stage NUM_STAGE SHALL update dout only when the carried valid bit is 1: acc_en=1 gives dout <= dout + product, mod 2^dout_WIDTH; acc_en=0 gives dout <= product.
REQ-021 An operation accepted at ce-enabled edge k SHALL appear on dout with vld_out=1 after ce-enabled edge k+NUM_STAGE-1, i.e. NUM_STAGE enabled edges total.
REQ-022 Edges with ce=0 SHALL NOT count toward latency; the pipeline SHALL freeze with no loss or duplication.
REQ-023 When the carried valid bit is 0 at a ce-enabled edge, dout and ovf_out SHALL hold, and vld_out SHALL go to 0.
REQ-024 Throughput SHALL be one operation per ce-enabled cycle; back-to-back accumulates SHALL chain without bubbles.
REQ-025 Overflow detection:
- SIGNED_MODE=0: ovf_out SHALL be the carry out of the accumulate add.
- SIGNED_MODE=1: ovf_out SHALL be set when both addends share a sign and the sum's sign differs.
- A load (acc_en=0) SHALL set ovf_out to 0.
REQ-026 Product truncation (REQ-018) SHALL NOT set ovf_out.
REQ-027 vld_out and ovf_out SHALL hold when ce=0.
REQ-028 The design SHALL contain no combinational path from any input to any output.

Reset
REQ-029 reset=1 at a rising edge SHALL clear dout, vld_out, ovf_out and all pipeline valid bits to 0, regardless of ce.
REQ-030 Operations in flight when reset asserts SHALL be discarded and never appear on vld_out.
REQ-031 Pipeline data registers other than valid bits need not be reset.
REQ-032 Inputs on the reset edge SHALL be ignored; the first accepted operation is on the first ce-enabled edge with reset=0.

Verification
REQ-033 Defaults, ce=1, one op din0=100, din1=3, acc_en=0 -> vld_out=1, dout=300 exactly 5 edges later; vld_out=0 on the following edge.
REQ-034 Four consecutive ops 2x5 (load), 3x4 (acc), 1x1 (acc), 10x10 (load) -> dout sequence 10, 22, 23, 100 on consecutive cycles, each with vld_out=1.
REQ-035 Single op, ce held low for 3 cycles mid-pipeline -> result appears 8 clk edges after acceptance (5 enabled), value correct, exactly one vld_out pulse.
REQ-036 dout_WIDTH=8, SIGNED_MODE=0: load 16x15=240, then accumulate 2x10=20 -> dout=4, ovf_out=1; then load 1x1 -> dout=1, ovf_out=0.
REQ-037 SIGNED_MODE=1, din0=-3, din1=7, load -> dout=-21 in two's complement; then accumulate 3x7 -> dout=0, ovf_out=0.
REQ-038 Reset asserted for 1 edge with 3 ops in flight -> dout=0, vld_out=0 for the next 5 edges; the next op completes normally.
